mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 16-bit pipeline, directly downstream of the EX/MEM pipeline register. It issues the data-memory load/store described by the EX/MEM outputs over a variable-latency req/ack handshake and stalls the front of the pipeline until the access completes. It also selects the writeback value and registers the MEM/WB state consumed by the register-file write port. An optional watchdog aborts accesses that are never acknowledged.

## Interface
Parameters:
- TIMEOUT, 16: maximum number of req cycles without ack before an access is aborted. Legal range 2..255. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- dmem_wen_exmem  in  1  store request
- mem2reg_exmem  in  1  load request / writeback selects memory data
- rf_wen_exmem  in  1  register-file write enable
- rf_waddr_exmem  in  4  destination register
- aluout_exmem  in  16  memory address / ALU result
- rdata2_exmem  in  16  store data
- nop_lw_exmem, nop_sw_exmem  in  1 each  suppress load / store (bubble)
- jal_exmem  in  1  writeback selects link address
- pc_added_exmem  in  16  link address (PC+1)
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  16  word address
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data, valid when dmem_ack=1
- dmem_ack  in  1  access complete
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- rf_wen_memwb  out  1  registered write enable
- rf_waddr_memwb  out  4  registered destination
- wb_data_memwb  out  16  registered writeback data
- dmem_err  out  1  sticky access-timeout flag

## Operation
- ld = mem2reg_exmem & ~nop_lw_exmem; st = dmem_wen_exmem & ~nop_sw_exmem; acc = ld | st. If both ld and st are set, st wins; dmem_we = st.
- Combinational outputs: dmem_req = rst_n & acc & (state != DONE); dmem_addr = aluout_exmem; dmem_wdata = rdata2_exmem.
- States: IDLE (no outstanding access) and WAIT (req issued, ack pending).
  - IDLE -> WAIT when dmem_req=1 and dmem_ack=0.
  - WAIT -> IDLE on dmem_ack=1 or on abort.
  - IDLE stays in IDLE when ack arrives in the same cycle as req.
- mem_stall = dmem_req & ~dmem_ack & ~abort.
- Completion cycle: the first cycle in which dmem_ack=1 or abort=1 while dmem_req=1. In that cycle mem_stall=0 and EX/MEM advances at the next edge.
- MEM/WB register, updated each edge:
  - When mem_stall=1: rf_wen_memwb<=0 (bubble). Address and data hold.
  - Otherwise: rf_wen_memwb<=rf_wen_exmem and rf_waddr_memwb<=rf_waddr_exmem.
  - wb_data_memwb <= jal ? pc_added : (mem2reg ? (ld ? load_data : 0) : aluout). Priority: jal, then mem2reg, then aluout.
  - load_data = dmem_rdata on ack, 0x0000 on abort.
- dmem_ack is ignored whenever dmem_req=0.
- State DONE is not used; the FSM encoding is 1 bit.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, wait counter=0, rf_wen_memwb=0, rf_waddr_memwb=0, wb_data_memwb=0x0000, dmem_err=0. dmem_req=0 and mem_stall=0 while rst_n=0.
- Reset asserted mid-access drops the access. No writeback occurs, and memory must tolerate req falling without ack.
- Zero-wait access (ack in the req cycle): mem_stall never asserts, and the result is in MEM/WB one edge later.
- An access acked N cycles after first req produces N stall cycles and N MEM/WB bubbles.
- Non-memory instructions pass through with 1-cycle latency.
- Back-to-back accesses: a new req may assert in the cycle right after completion. No idle cycle is required.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter counts consecutive cycles with dmem_req=1 and dmem_ack=0. It clears on completion or when dmem_req=0.
  - abort=1 when the counter equals TIMEOUT-1 and dmem_ack=0.
  - On abort: dmem_err sets (cleared only by reset), and a load writes back 0x0000.
- MEM_TIMEOUT_EN undefined: abort=0 and dmem_err is tied 0. The block waits indefinitely and contains no counter logic.

## Test plan
- Reset: hold rst_n=0 with ld requested -> dmem_req=0, mem_stall=0, all MEM/WB outputs 0, dmem_err=0.
- Zero-wait load: addr 0x0040, rf_waddr 5, ack in the same cycle with rdata 0xBEEF -> no stall; next cycle rf_wen_memwb=1, rf_waddr_memwb=5, wb_data_memwb=0xBEEF.
- Store with 3-cycle latency: addr 0x0010, data 0x1234 -> dmem_we=1 for 3 cycles; mem_stall=1 for 2 cycles with 2 MEM/WB bubbles; req drops after ack.
- nop_lw_exmem=1 with mem2reg=1 -> dmem_req=0, no stall, wb_data_memwb=0x0000. jal with pc_added=0x0021 -> wb_data_memwb=0x0021.
- MEM_TIMEOUT_EN, TIMEOUT=4, ack never returned on a load -> stall for 3 cycles, abort on the 4th, wb_data_memwb=0x0000, dmem_err=1 held until reset.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 16-bit pipeline. It issues the EX/MEM load or store over a req/ack handshake, stalls the front of the pipeline until the access completes, and registers the MEM/WB writeback state.
// Ports: i_clk, i_rst_n (sync, active-low); EX/MEM inputs i_*_exmem; data-memory port o_dmem_req/we/addr/wdata, i_dmem_rdata/ack;
//        o_mem_stall freezes upstream stages; MEM/WB outputs o_rf_wen_memwb, o_rf_waddr_memwb, o_wb_data_memwb; o_dmem_err sticky timeout flag.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses left unacknowledged for TIMEOUT req cycles.
module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_dmem_wen_exmem,
   input  logic        i_mem2reg_exmem,
   input  logic        i_rf_wen_exmem,
   input  logic [3:0]  i_rf_waddr_exmem,
   input  logic [15:0] i_aluout_exmem,
   input  logic [15:0] i_rdata2_exmem,
   input  logic        i_nop_lw_exmem,
   input  logic        i_nop_sw_exmem,
   input  logic        i_jal_exmem,
   input  logic [15:0] i_pc_added_exmem,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [15:0] o_dmem_addr,
   output logic [15:0] o_dmem_wdata,
   input  logic [15:0] i_dmem_rdata,
   input  logic        i_dmem_ack,
   output logic        o_mem_stall,
   output logic        o_rf_wen_memwb,
   output logic [3:0]  o_rf_waddr_memwb,
   output logic [15:0] o_wb_data_memwb,
   output logic        o_dmem_err
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t      r_state, w_next;
   logic        w_ld, w_st, w_abort;
   logic [15:0] w_wb_data;
   logic        r_rf_wen;
   logic [3:0]  r_rf_waddr;
   logic [15:0] r_wb_data;
   assign w_ld         = i_mem2reg_exmem & ~i_nop_lw_exmem;
   assign w_st         = i_dmem_wen_exmem & ~i_nop_sw_exmem;
   assign o_dmem_req   = i_rst_n & (w_ld | w_st);
   assign o_dmem_we    = w_st;
   assign o_dmem_addr  = i_aluout_exmem;
   assign o_dmem_wdata = i_rdata2_exmem;
   assign o_mem_stall  = o_dmem_req & ~i_dmem_ack & ~w_abort;
`ifdef MEM_TIMEOUT_EN
   logic [7:0] r_cnt;
   logic       r_err;
   // Counter reaches TIMEOUT-1 on the TIMEOUT-th unacknowledged req cycle.
   assign w_abort    = o_dmem_req & ~i_dmem_ack & (r_cnt == 8'(TIMEOUT - 1));
   assign o_dmem_err = r_err;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= 8'd0;
         r_err <= 1'b0;
      end else begin
         r_cnt <= o_mem_stall ? r_cnt + 8'd1 : 8'd0;
         r_err <= r_err | w_abort;
      end
   end
`else
   assign w_abort    = 1'b0;
   assign o_dmem_err = 1'b0;
`endif
   // An aborted load has no ack, so it writes back zero.
   assign w_wb_data = i_jal_exmem ? i_pc_added_exmem :
                      i_mem2reg_exmem ? ((w_ld & i_dmem_ack) ? i_dmem_rdata : 16'h0000) :
                      i_aluout_exmem;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = o_mem_stall ? WAIT : IDLE;
         default: w_next = (~o_dmem_req | i_dmem_ack | w_abort) ? IDLE : WAIT;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_rf_wen   <= 1'b0;
         r_rf_waddr <= 4'd0;
         r_wb_data  <= 16'h0000;
      end else begin
         r_state  <= w_next;
         r_rf_wen <= ~o_mem_stall & i_rf_wen_exmem;
         if (!o_mem_stall) begin
            r_rf_waddr <= i_rf_waddr_exmem;
            r_wb_data  <= w_wb_data;
         end
      end
   end
   assign o_rf_wen_memwb   = r_rf_wen;
   assign o_rf_waddr_memwb = r_rf_waddr;
   assign o_wb_data_memwb  = r_wb_data;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst_n, dmem_wen, mem2reg, rf_wen, nop_lw, nop_sw, jal, ack;
   logic [3:0]  waddr;
   logic [15:0] alu, rdata2, pc_added, rdata;
   logic        req, we, stall, wb_wen, err;
   logic [15:0] addr, wdata, wb_data;
   logic [3:0]  wb_waddr;
   int          n_eval = 0;
   int          n_fail = 0;
   typedef struct packed {logic wen; logic [3:0] wa; logic [15:0] wd;} wb_t;
   wb_t         q[$];
   logic [3:0]  m_waddr = 4'd0;
   logic [15:0] m_data = 16'h0000;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_dmem_wen_exmem(dmem_wen), .i_mem2reg_exmem(mem2reg),
      .i_rf_wen_exmem(rf_wen), .i_rf_waddr_exmem(waddr), .i_aluout_exmem(alu),
      .i_rdata2_exmem(rdata2), .i_nop_lw_exmem(nop_lw), .i_nop_sw_exmem(nop_sw),
      .i_jal_exmem(jal), .i_pc_added_exmem(pc_added), .o_dmem_req(req), .o_dmem_we(we),
      .o_dmem_addr(addr), .o_dmem_wdata(wdata), .i_dmem_rdata(rdata), .i_dmem_ack(ack),
      .o_mem_stall(stall), .o_rf_wen_memwb(wb_wen), .o_rf_waddr_memwb(wb_waddr),
      .o_wb_data_memwb(wb_data), .o_dmem_err(err)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_eval++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_adv(input logic w, input logic [3:0] a, input logic [15:0] d);
      q.push_back('{w, a, d});
      m_waddr = a;
      m_data  = d;
   endtask

   task automatic push_stall();
      q.push_back('{1'b0, m_waddr, m_data});
   endtask

   task automatic tick();
      wb_t e;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("wb_wen", {15'd0, wb_wen}, {15'd0, e.wen});
         chk("wb_waddr", {12'd0, wb_waddr}, {12'd0, e.wa});
         chk("wb_data", wb_data, e.wd);
      end
   endtask

   task automatic idle();
      dmem_wen = 0; mem2reg = 0; rf_wen = 0; nop_lw = 0; nop_sw = 0; jal = 0; ack = 0;
      waddr = 0; alu = 0; rdata2 = 0; pc_added = 0; rdata = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst_n = 0; mem2reg = 1; rf_wen = 1; waddr = 4'd7; alu = 16'h0040;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {15'd0, req}, 16'd0);
      chk("rst_stall", {15'd0, stall}, 16'd0);
      chk("rst_wen", {15'd0, wb_wen}, 16'd0);
      chk("rst_waddr", {12'd0, wb_waddr}, 16'd0);
      chk("rst_data", wb_data, 16'h0000);
      chk("rst_err", {15'd0, err}, 16'd0);
      idle(); rst_n = 1;
      push_adv(0, 0, 0); tick();
      // zero-wait load
      mem2reg = 1; rf_wen = 1; waddr = 5; alu = 16'h0040; ack = 1; rdata = 16'hBEEF;
      #1;
      chk("zw_req", {15'd0, req}, 16'd1);
      chk("zw_we", {15'd0, we}, 16'd0);
      chk("zw_addr", addr, 16'h0040);
      chk("zw_stall", {15'd0, stall}, 16'd0);
      push_adv(1, 5, 16'hBEEF); tick();
      // store, 3-cycle latency
      idle(); dmem_wen = 1; alu = 16'h0010; rdata2 = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         ack = (i == 2);
         #1;
         chk("st_req", {15'd0, req}, 16'd1);
         chk("st_we", {15'd0, we}, 16'd1);
         chk("st_addr", addr, 16'h0010);
         chk("st_wdata", wdata, 16'h1234);
         chk("st_stall", {15'd0, stall}, {15'd0, i < 2});
         if (i < 2) push_stall(); else push_adv(0, 0, 16'h0010);
         tick();
      end
      // plain ALU op after completion
      idle(); rf_wen = 1; waddr = 3; alu = 16'h7777;
      #1;
      chk("alu_req", {15'd0, req}, 16'd0);
      chk("alu_stall", {15'd0, stall}, 16'd0);
      push_adv(1, 3, 16'h7777); tick();
      // load acked one cycle late: one bubble
      idle(); mem2reg = 1; rf_wen = 1; waddr = 9; alu = 16'h0100;
      #1;
      chk("ld2_stall", {15'd0, stall}, 16'd1);
      push_stall(); tick();
      ack = 1; rdata = 16'hCAFE;
      #1;
      chk("ld2_done", {15'd0, stall}, 16'd0);
      push_adv(1, 9, 16'hCAFE); tick();
      // back-to-back zero-wait store
      idle(); dmem_wen = 1; ack = 1; alu = 16'h0200;
      #1;
      chk("b2b_req", {15'd0, req}, 16'd1);
      chk("b2b_stall", {15'd0, stall}, 16'd0);
      push_adv(0, 0, 16'h0200); tick();
      // ack without req is ignored
      idle(); ack = 1; rdata = 16'hFFFF; rf_wen = 1; waddr = 2; alu = 16'h0055;
      #1;
      chk("noreq_req", {15'd0, req}, 16'd0);
      push_adv(1, 2, 16'h0055); tick();
      // suppressed load
      idle(); mem2reg = 1; nop_lw = 1; rf_wen = 1; waddr = 4; alu = 16'h0040;
      #1;
      chk("noplw_req", {15'd0, req}, 16'd0);
      chk("noplw_stall", {15'd0, stall}, 16'd0);
      push_adv(1, 4, 16'h0000); tick();
      // jal link writeback
      idle(); jal = 1; pc_added = 16'h0021; rf_wen = 1; waddr = 15; alu = 16'h1111;
      #1;
      push_adv(1, 15, 16'h0021); tick();
      // reset in the middle of an access
      idle(); mem2reg = 1; rf_wen = 1; waddr = 8; alu = 16'h0080;
      #1;
      push_stall(); tick();
      rst_n = 0;
      #1;
      chk("midrst_req", {15'd0, req}, 16'd0);
      chk("midrst_stall", {15'd0, stall}, 16'd0);
      push_adv(0, 0, 0); tick();
      idle(); rst_n = 1;
      push_adv(0, 0, 0); tick();
`ifdef MEM_TIMEOUT_EN
      mem2reg = 1; rf_wen = 1; waddr = 6; alu = 16'h0300;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("to_req", {15'd0, req}, 16'd1);
         chk("to_stall", {15'd0, stall}, {15'd0, i < 3});
         if (i < 3) push_stall(); else push_adv(1, 6, 16'h0000);
         tick();
      end
      idle();
      chk("to_err", {15'd0, err}, 16'd1);
      push_adv(0, 0, 0); tick();
      push_adv(0, 0, 0); tick();
      chk("to_err_hold", {15'd0, err}, 16'd1);
      rst_n = 0;
      push_adv(0, 0, 0); tick();
      chk("to_err_rst", {15'd0, err}, 16'd0);
      rst_n = 1;
`else
      // without the watchdog an unacked access stalls indefinitely
      mem2reg = 1; rf_wen = 1; waddr = 6; alu = 16'h0300;
      for (int i = 0; i < 20; i++) begin
         push_stall(); tick();
      end
      chk("nto_stall", {15'd0, stall}, 16'd1);
      chk("nto_err", {15'd0, err}, 16'd0);
      ack = 1; rdata = 16'h4321;
      #1;
      push_adv(1, 6, 16'h4321); tick();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end
endmodule
